noc_switch_allocator: RTL and testbench

Per-output round-robin switch allocator with credit-based flow control for the 4-port mesh NoC router. It sits between the router's input FIFOs and the crossbar. Each cycle it grants each output port to at most one input. It holds an output for a whole wormhole packet, from head flit to tail flit, and tracks downstream buffer credits per output. It replaces fixed lowest-index priority, so no input can be starved.

---
 rtl/noc_switch_allocator_if.sv | 27 ++
 rtl/noc_switch_allocator.sv | 105 ++++++++++
 tb/tb_noc_switch_allocator.sv | 366 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/noc_switch_allocator_if.sv
// Request/grant bundle between the router input FIFOs, the switch allocator
// and the crossbar. The allocator takes the slave side.
interface noc_switch_allocator_if #(
  parameter int NPORT  = 4,
  parameter int DEST_W = 2,
  parameter int CNT_W  = 3
);
  logic [NPORT-1:0]        req_valid;
  logic [NPORT*DEST_W-1:0] req_dest;
  logic [NPORT-1:0]        req_tail;
  logic [NPORT-1:0]        credit_ret;
  logic [NPORT-1:0]        grant;
  logic [NPORT-1:0]        xbar_valid;
  logic [NPORT*DEST_W-1:0] xbar_sel;
  logic [NPORT*CNT_W-1:0]  credit_avail;
  logic                    credit_err;

  modport master (
    output req_valid, req_dest, req_tail, credit_ret,
    input  grant, xbar_valid, xbar_sel, credit_avail, credit_err
  );

  modport slave (
    input  req_valid, req_dest, req_tail, credit_ret,
    output grant, xbar_valid, xbar_sel, credit_avail, credit_err
  );
endinterface

// File: rtl/noc_switch_allocator.sv
// Per-output round-robin switch allocator with wormhole locking and
// credit-based flow control. Grants are combinational from registered
// state and same-cycle requests; all bookkeeping updates on the clock edge.
module noc_switch_allocator #(
  parameter int NPORT   = 4,
  parameter int DEST_W  = 2,
  parameter int CREDITS = 4,
  parameter int CNT_W   = 3
) (
  input logic                  clk,
  input logic                  rst,
  noc_switch_allocator_if.slave bus
);

  localparam logic [CNT_W-1:0] CRED_MAX = CNT_W'(CREDITS);

  logic [NPORT-1:0]        lock_vld;
  logic [DEST_W-1:0]       lock_src [NPORT];
  logic [DEST_W-1:0]       rr_ptr   [NPORT];
  logic [CNT_W-1:0]        cred     [NPORT];
  logic                    credit_err_q;

  logic [NPORT-1:0]        go;
  logic [NPORT*DEST_W-1:0] sel_flat;
  logic [NPORT-1:0]        grant_c;

  for (genvar j = 0; j < NPORT; j++) begin : g_out
    logic [NPORT-1:0]  elig;
    logic              found;
    logic [DEST_W-1:0] pick;
    logic [DEST_W-1:0] idx;

    // Eligibility mask (narrowed to the lock owner mid-packet), then a
    // round-robin search starting at the pointer; the index wraps naturally
    // because NPORT is a power of two.
    always_comb begin
      elig  = '0;
      found = 1'b0;
      pick  = '0;
      idx   = '0;
      for (int i = 0; i < NPORT; i++) begin
        elig[i] = bus.req_valid[i] && (bus.req_dest[i*DEST_W +: DEST_W] == DEST_W'(j));
      end
      if (lock_vld[j]) begin
        elig = elig & (NPORT'(1) << lock_src[j]);
      end
      for (int k = 0; k < NPORT; k++) begin
        idx = rr_ptr[j] + DEST_W'(k);
        if (!found && elig[idx]) begin
          found = 1'b1;
          pick  = idx;
        end
      end
    end

    // Only the registered count gates a grant; a same-cycle return does not.
    assign go[j] = found && (cred[j] != '0) && !rst;
    assign sel_flat[j*DEST_W +: DEST_W]    = go[j] ? pick : '0;
    assign bus.credit_avail[j*CNT_W +: CNT_W] = cred[j];
  end

  // Each input names one destination, so grant is a plain OR of winners.
  always_comb begin
    grant_c = '0;
    for (int j = 0; j < NPORT; j++) begin
      if (go[j]) grant_c[sel_flat[j*DEST_W +: DEST_W]] = 1'b1;
    end
  end

  assign bus.grant      = grant_c;
  assign bus.xbar_valid = go;
  assign bus.xbar_sel   = sel_flat;
  assign bus.credit_err = credit_err_q;

  // Lock, pointer and credit bookkeeping per output; pointer moves only on tails.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_vld     <= '0;
      credit_err_q <= 1'b0;
      for (int j = 0; j < NPORT; j++) begin
        lock_src[j] <= '0;
        rr_ptr[j]   <= '0;
        cred[j]     <= CRED_MAX;
      end
    end else begin
      for (int j = 0; j < NPORT; j++) begin
        if (go[j]) begin
          if (bus.req_tail[sel_flat[j*DEST_W +: DEST_W]]) begin
            lock_vld[j] <= 1'b0;
            rr_ptr[j]   <= sel_flat[j*DEST_W +: DEST_W] + DEST_W'(1);
          end else begin
            lock_vld[j] <= 1'b1;
            lock_src[j] <= sel_flat[j*DEST_W +: DEST_W];
          end
        end
        if (bus.credit_ret[j] && !go[j] && (cred[j] == CRED_MAX)) begin
          credit_err_q <= 1'b1;
        end else begin
          cred[j] <= cred[j] - CNT_W'(go[j]) + CNT_W'(bus.credit_ret[j]);
        end
      end
    end
  end

endmodule

// File: tb/tb_noc_switch_allocator.sv
`timescale 1ns/1ps
module tb_noc_switch_allocator;
  localparam int NP = 4;
  localparam int DW = 2;
  localparam int CW = 3;
  localparam int CR = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  noc_switch_allocator_if #(.NPORT(NP), .DEST_W(DW), .CNT_W(CW)) bus ();

  noc_switch_allocator #(.NPORT(NP), .DEST_W(DW), .CREDITS(CR), .CNT_W(CW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // ---------------- reference model (spec-level, integer arithmetic) ----------
  int m_cred [NP];
  int m_lock [NP];   // -1 = no packet in flight
  int m_ptr  [NP];
  int m_own  [NP];   // winner this cycle, -1 = none
  bit m_err;
  logic [NP-1:0]    e_grant, e_xv;
  logic [NP*DW-1:0] e_sel;
  logic [NP*CW-1:0] e_cred;

  function automatic int dest_of(int i);
    return int'(bus.req_dest[i*DW +: DW]);
  endfunction

  task automatic model_reset();
    for (int j = 0; j < NP; j++) begin
      m_cred[j] = CR; m_lock[j] = -1; m_ptr[j] = 0; m_own[j] = -1;
    end
    m_err = 1'b0;
  endtask

  task automatic model_eval();
    e_grant = '0; e_xv = '0; e_sel = '0; e_cred = '0;
    for (int j = 0; j < NP; j++) begin
      m_own[j] = -1;
      if (m_cred[j] > 0) begin
        if (m_lock[j] >= 0) begin
          if (bus.req_valid[m_lock[j]] && dest_of(m_lock[j]) == j) m_own[j] = m_lock[j];
        end else begin
          for (int k = 0; k < NP; k++) begin
            int i;
            i = (m_ptr[j] + k) % NP;
            if (m_own[j] < 0 && bus.req_valid[i] && dest_of(i) == j) m_own[j] = i;
          end
        end
      end
      if (m_own[j] >= 0) begin
        e_grant[m_own[j]] = 1'b1;
        e_xv[j] = 1'b1;
        e_sel[j*DW +: DW] = m_own[j][DW-1:0];
      end
      e_cred[j*CW +: CW] = m_cred[j][CW-1:0];
    end
  endtask

  task automatic model_update();
    for (int j = 0; j < NP; j++) begin
      int used;
      used = (m_own[j] >= 0) ? 1 : 0;
      if (used == 1) begin
        if (bus.req_tail[m_own[j]]) begin
          m_lock[j] = -1;
          m_ptr[j] = (m_own[j] + 1) % NP;
        end else begin
          m_lock[j] = m_own[j];
        end
      end
      if (bus.credit_ret[j] && used == 0 && m_cred[j] == CR) m_err = 1'b1;
      else m_cred[j] = m_cred[j] - used + (bus.credit_ret[j] ? 1 : 0);
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic clear_inputs();
    bus.req_valid = '0; bus.req_dest = '0; bus.req_tail = '0; bus.credit_ret = '0;
  endtask

  task automatic set_req(input int i, input bit v, input int d, input bit t);
    bus.req_valid[i] = v;
    bus.req_dest[i*DW +: DW] = d[DW-1:0];
    bus.req_tail[i] = t;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    clear_inputs();
    set_req(0, 1, 0, 1);
    rst = 1'b1;
    #2;
    checks++;
    if (bus.grant !== 4'b0 || bus.xbar_valid !== 4'b0 || bus.xbar_sel !== 8'h00) begin
      errors++;
      $display("FAIL reset_outputs: got grant=%b xv=%b sel=%h, expected all zero",
               bus.grant, bus.xbar_valid, bus.xbar_sel);
    end
    checks++;
    if (bus.credit_avail !== 12'h924 || bus.credit_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_credits: got cred=%h err=%b, expected 924 0",
               bus.credit_avail, bus.credit_err);
    end
    advance();
    rst = 1'b0;
    clear_inputs();
  endtask

  task automatic test_fairness();
    int seq [5] = '{0, 1, 2, 3, 0};
    do_reset();
    for (int i = 0; i < NP; i++) set_req(i, 1, 2, 1);
    bus.credit_ret[2] = 1'b1;
    for (int c = 0; c < 5; c++) begin
      logic [NP-1:0] eg;
      eg = '0;
      eg[seq[c]] = 1'b1;
      settle();
      checks++;
      if (bus.grant !== eg || bus.xbar_sel[2*DW +: DW] !== seq[c][DW-1:0]) begin
        errors++;
        $display("FAIL fairness c%0d: got grant=%b sel2=%0d, expected grant=%b sel2=%0d",
                 c, bus.grant, bus.xbar_sel[2*DW +: DW], eg, seq[c]);
      end
      advance();
    end
    checks++;
    if (bus.credit_avail[2*CW +: CW] !== 3'd4 || bus.credit_err !== 1'b0) begin
      errors++;
      $display("FAIL fairness_credit: got cred2=%0d err=%b, expected 4 0",
               bus.credit_avail[2*CW +: CW], bus.credit_err);
    end
    clear_inputs();
  endtask

  task automatic test_wormhole();
    do_reset();
    set_req(3, 1, 0, 1);
    for (int c = 0; c < 3; c++) begin
      set_req(1, 1, 0, (c == 2));
      settle();
      checks++;
      if (bus.grant !== 4'b0010 || bus.xbar_sel[0 +: DW] !== 2'd1) begin
        errors++;
        $display("FAIL wormhole_flit%0d: got grant=%b sel0=%0d, expected 0010 1",
                 c, bus.grant, bus.xbar_sel[0 +: DW]);
      end
      advance();
    end
    set_req(1, 0, 0, 0);
    set_req(0, 1, 0, 1);
    settle();
    checks++;
    if (bus.grant !== 4'b1000 || bus.xbar_sel[0 +: DW] !== 2'd3) begin
      errors++;
      $display("FAIL wormhole_after_tail: got grant=%b sel0=%0d, expected 1000 3",
               bus.grant, bus.xbar_sel[0 +: DW]);
    end
    advance();
    clear_inputs();
  endtask

  task automatic test_credit_exhaust();
    int ng;
    do_reset();
    set_req(0, 1, 1, 1);
    ng = 0;
    for (int c = 0; c < 6; c++) begin
      settle();
      if (bus.grant[0]) ng++;
      advance();
    end
    checks++;
    if (ng != 4 || bus.credit_avail[1*CW +: CW] !== 3'd0) begin
      errors++;
      $display("FAIL credit_exhaust: got %0d grants cred1=%0d, expected 4 grants cred1=0",
               ng, bus.credit_avail[1*CW +: CW]);
    end
    bus.credit_ret[1] = 1'b1;
    settle();
    checks++;
    if (bus.grant !== 4'b0) begin
      errors++;
      $display("FAIL credit_same_cycle: got grant=%b, expected 0000", bus.grant);
    end
    advance();
    bus.credit_ret[1] = 1'b0;
    settle();
    checks++;
    if (bus.grant !== 4'b0001) begin
      errors++;
      $display("FAIL credit_return_grant: got grant=%b, expected 0001", bus.grant);
    end
    advance();
    settle();
    checks++;
    if (bus.grant !== 4'b0 || bus.credit_avail[1*CW +: CW] !== 3'd0) begin
      errors++;
      $display("FAIL credit_one_only: got grant=%b cred1=%0d, expected 0000 0",
               bus.grant, bus.credit_avail[1*CW +: CW]);
    end
    advance();
    clear_inputs();
  endtask

  task automatic test_credit_balance();
    do_reset();
    set_req(0, 1, 3, 1);
    advance();
    advance();
    bus.credit_ret[3] = 1'b1;
    settle();
    checks++;
    if (bus.grant !== 4'b0001) begin
      errors++;
      $display("FAIL balance_grant: got grant=%b, expected 0001", bus.grant);
    end
    advance();
    checks++;
    if (bus.credit_avail[3*CW +: CW] !== 3'd2) begin
      errors++;
      $display("FAIL balance_count: got cred3=%0d, expected 2", bus.credit_avail[3*CW +: CW]);
    end
    set_req(0, 0, 0, 0);
    advance();
    advance();
    checks++;
    if (bus.credit_avail[3*CW +: CW] !== 3'd4 || bus.credit_err !== 1'b0) begin
      errors++;
      $display("FAIL refill: got cred3=%0d err=%b, expected 4 0",
               bus.credit_avail[3*CW +: CW], bus.credit_err);
    end
    advance();
    bus.credit_ret[3] = 1'b0;
    advance();
    checks++;
    if (bus.credit_avail[3*CW +: CW] !== 3'd4 || bus.credit_err !== 1'b1) begin
      errors++;
      $display("FAIL overflow: got cred3=%0d err=%b, expected 4 1",
               bus.credit_avail[3*CW +: CW], bus.credit_err);
    end
    clear_inputs();
  endtask

  task automatic test_parallel();
    do_reset();
    set_req(0, 1, 1, 1);
    set_req(1, 1, 2, 1);
    set_req(2, 1, 3, 1);
    set_req(3, 1, 0, 1);
    settle();
    checks++;
    if (bus.grant !== 4'b1111 || bus.xbar_valid !== 4'b1111 || bus.xbar_sel !== 8'b10_01_00_11) begin
      errors++;
      $display("FAIL parallel: got grant=%b xv=%b sel=%b, expected 1111 1111 10010011",
               bus.grant, bus.xbar_valid, bus.xbar_sel);
    end
    advance();
    clear_inputs();
  endtask

  task automatic test_reset_mid_packet();
    do_reset();
    set_req(2, 1, 0, 0);
    settle();
    checks++;
    if (bus.grant !== 4'b0100) begin
      errors++;
      $display("FAIL midpkt_head: got grant=%b, expected 0100", bus.grant);
    end
    advance();
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.grant !== 4'b0 || bus.xbar_valid !== 4'b0 || bus.xbar_sel !== 8'h00 ||
        bus.credit_avail !== 12'h924) begin
      errors++;
      $display("FAIL midpkt_reset: got grant=%b xv=%b sel=%h cred=%h, expected 0 0 00 924",
               bus.grant, bus.xbar_valid, bus.xbar_sel, bus.credit_avail);
    end
    advance();
    rst = 1'b0;
    set_req(0, 1, 0, 0);
    settle();
    checks++;
    if (bus.grant !== 4'b0001 || bus.xbar_sel[0 +: DW] !== 2'd0 || bus.xbar_valid[0] !== 1'b1) begin
      errors++;
      $display("FAIL midpkt_release: got grant=%b sel0=%0d, expected 0001 0",
               bus.grant, bus.xbar_sel[0 +: DW]);
    end
    advance();
    clear_inputs();
  endtask

  task automatic test_random();
    do_reset();
    model_reset();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NP; i++) begin
        set_req(i, ($urandom_range(9) < 7), int'($urandom_range(NP-1)), ($urandom_range(1) == 1));
        bus.credit_ret[i] = ($urandom_range(9) < 3);
      end
      settle();
      model_eval();
      checks++;
      if (bus.grant !== e_grant || bus.xbar_valid !== e_xv || bus.xbar_sel !== e_sel) begin
        errors++;
        $display("FAIL random_grant c%0d: got grant=%b xv=%b sel=%h, expected %b %b %h",
                 c, bus.grant, bus.xbar_valid, bus.xbar_sel, e_grant, e_xv, e_sel);
      end
      checks++;
      if (bus.credit_avail !== e_cred || bus.credit_err !== m_err) begin
        errors++;
        $display("FAIL random_credit c%0d: got cred=%h err=%b, expected %h %b",
                 c, bus.credit_avail, bus.credit_err, e_cred, m_err);
      end
      @(posedge clk);
      model_update();
      #1;
    end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_fairness();
    test_wormhole();
    test_credit_exhaust();
    test_credit_balance();
    test_parallel();
    test_reset_mid_packet();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
